// File: rtl/gpio_disp_pkg.sv
// gpio_disp_pkg: shared constants and types for the GPIO hex display.
//   - state_e      : conversion FSM states
//   - WIDTH/DIGITS : input width and number of BCD digits / displays
//   - SEG_*        : active-low seven-segment codes (bit0 = a .. bit6 = g)
//   - DISP_LIMIT   : largest value that fits in eight decimal digits
package gpio_disp_pkg;

  localparam int WIDTH  = 32;
  localparam int DIGITS = 8;

  localparam logic [WIDTH-1:0] DISP_LIMIT = 32'd99_999_999;

  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;

  // Indexed directly by a BCD nibble; codes 10..15 never occur after a
  // valid conversion and map to blank so the decoder stays total.
  localparam logic [15:0][6:0] SEG_TABLE = {
    {6{SEG_BLANK}},
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, SEG_ZERO
  };

  typedef enum logic [1:0] {IDLE, CONV, UPD} state_e;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD digit to active-low segment pattern.
//   bcd : 4-bit BCD digit
//   seg : segments, bit0 = a .. bit6 = g, active-low
module seg7_decode
  import gpio_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[bcd];

endmodule

// File: rtl/gpio_hex_display.sv
// gpio_hex_display: converts the CPU GPIO word to eight decimal digits with a
// bit-serial double-dabble engine and drives eight active-low 7-seg displays.
// The HEX registers only update when a conversion completes, so the display
// never shows intermediate shift states.
//   clk, rst_n   : clock, async active-low reset
//   value_in     : unsigned 32-bit value to display
//   HEX0..HEX7   : active-low segments, HEX0 = least significant digit
//   busy         : conversion in flight
//   overflow     : displayed value exceeds 99,999,999 (all dashes shown)
// Build option: GPIO_HEX_LEADING_BLANK_EN blanks leading zero digits.
module gpio_hex_display
  import gpio_disp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] value_in,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3,
  output logic [6:0]       HEX4,
  output logic [6:0]       HEX5,
  output logic [6:0]       HEX6,
  output logic [6:0]       HEX7,
  output logic             busy,
  output logic             overflow
);

`ifdef GPIO_HEX_LEADING_BLANK_EN
  localparam logic [DIGITS-1:0][6:0] HEX_RST = {{(DIGITS-1){SEG_BLANK}}, SEG_ZERO};
`else
  localparam logic [DIGITS-1:0][6:0] HEX_RST = {DIGITS{SEG_ZERO}};
`endif

  state_e                   state, state_n;
  logic [4:0]               cnt;
  logic [WIDTH-1:0]         shift_q;
  logic [WIDTH-1:0]         last_val;
  logic [DIGITS-1:0][3:0]   bcd_q;
  logic [DIGITS-1:0][3:0]   bcd_adj;
  logic [2*WIDTH-1:0]       dd_next;
  logic                     ovf_pend;
  logic [DIGITS-1:0][6:0]   seg;
  logic [DIGITS-1:0][6:0]   disp;
  logic [DIGITS-1:0][6:0]   hex_q;

`ifdef GPIO_HEX_LEADING_BLANK_EN
  // lead_zero[i]: digit i and every digit above it are zero
  logic [DIGITS:0]          lead_zero;
  assign lead_zero[DIGITS] = 1'b1;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    assign bcd_adj[g] = (bcd_q[g] >= 4'd5) ? bcd_q[g] + 4'd3 : bcd_q[g];

    seg7_decode u_dec (.bcd(bcd_q[g]), .seg(seg[g]));

`ifdef GPIO_HEX_LEADING_BLANK_EN
    assign lead_zero[g] = (bcd_q[g] == 4'd0) && lead_zero[g+1];
    if (g == 0) begin : g_lsd
      // units digit always shows, so zero reads as a single "0"
      assign disp[g] = ovf_pend ? SEG_DASH : seg[g];
    end else begin : g_upper
      assign disp[g] = ovf_pend     ? SEG_DASH  :
                       lead_zero[g] ? SEG_BLANK : seg[g];
    end
`else
    assign disp[g] = ovf_pend ? SEG_DASH : seg[g];
`endif
  end

  // one double-dabble step: add-3 correction, then shift {bcd, shift} left
  assign dd_next = {bcd_adj, shift_q} << 1;

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (value_in != last_val) state_n = CONV;
      CONV: if (cnt == 5'(WIDTH-1))   state_n = UPD;
      UPD:                            state_n = IDLE;
      default:                        state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      shift_q  <= '0;
      last_val <= '0;
      bcd_q    <= '0;
      ovf_pend <= 1'b0;
      overflow <= 1'b0;
      hex_q    <= HEX_RST;
    end else begin
      case (state)
        IDLE: if (value_in != last_val) begin
          shift_q  <= value_in;
          last_val <= value_in;
          bcd_q    <= '0;
          ovf_pend <= (value_in > DISP_LIMIT);
          cnt      <= '0;
        end
        CONV: begin
          {bcd_q, shift_q} <= dd_next;
          cnt              <= cnt + 5'd1;
        end
        UPD: begin
          hex_q    <= disp;
          overflow <= ovf_pend;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];
  assign HEX6 = hex_q[6];
  assign HEX7 = hex_q[7];

endmodule

// File: tb/tb_gpio_hex_display.sv
// tb_gpio_hex_display: self-checking bench for gpio_hex_display. Expected
// displays come from a decimal-arithmetic model of the value.
module tb_gpio_hex_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] value_in = '0;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
  logic        busy, overflow;
  logic [7:0][6:0] hex_all;

  int checks = 0;
  int failures = 0;

  gpio_hex_display dut (
    .clk(clk), .rst_n(rst_n), .value_in(value_in),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
    .HEX4(HEX4), .HEX5(HEX5), .HEX6(HEX6), .HEX7(HEX7),
    .busy(busy), .overflow(overflow)
  );

  assign hex_all = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
      4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
      8: return 7'h00; default: return 7'h10;
    endcase
  endfunction

  function automatic logic model_ovf(input logic [31:0] v);
    return longint'(v) > 64'd99_999_999;
  endfunction

  function automatic logic [7:0][6:0] model_hex(input logic [31:0] v);
    logic [7:0][6:0] r;
    longint x = longint'(v);
    longint p = 1;
    if (model_ovf(v)) return {8{7'h3F}};
    for (int i = 0; i < 8; i++) begin
      r[i] = seg_of(int'((x / p) % 10));
`ifdef GPIO_HEX_LEADING_BLANK_EN
      if (i > 0 && x < p) r[i] = 7'h7F;
`endif
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [7:0][6:0] reset_hex();
`ifdef GPIO_HEX_LEADING_BLANK_EN
    return {{7{7'h7F}}, 7'h40};
`else
    return {8{7'h40}};
`endif
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    value_in = '0;
    #12;
    checks++;
    if (hex_all !== reset_hex() || busy !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: hex=%h busy=%b ovf=%b, expected hex=%h busy=0 ovf=0",
               hex_all, busy, overflow, reset_hex());
    end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk) #1;
      checks++;
      if (busy !== 1'b0 || hex_all !== reset_hex()) begin
        failures++;
        $display("FAIL idle_zero cycle %0d: busy=%b hex=%h, expected busy=0 hex=%h",
                 k, busy, hex_all, reset_hex());
      end
    end
  endtask

  // Each value: capture at E0, busy through E32, display valid after E33.
  task automatic test_conversions();
    logic [31:0] vals[$];
    logic [31:0] prev = 32'd0;
    logic [31:0] v;
    int edges;
    vals = '{32'hEA, 32'd99_999_999, 32'd100_000_000, 32'd0, 32'd1, 32'd10, 32'hFFFF_FFFF};
    for (int i = 0; i < 8; i++) begin
      do v = (i % 2 == 0) ? $urandom_range(99_999_999, 0) : $urandom();
      while (v == vals[$]);
      vals.push_back(v);
    end
    foreach (vals[i]) begin
      v = vals[i];
      if (v == prev) continue;
      prev = v;
      @(negedge clk) value_in = v;
      @(posedge clk) #1;
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL conv_start %h: busy=%b, expected 1", v, busy);
      end
      edges = 0;
      while (busy === 1'b1 && edges < 40) begin
        @(posedge clk) #1;
        edges++;
      end
      checks++;
      if (edges != 33) begin
        failures++;
        $display("FAIL conv_latency %h: busy fell after %0d edges, expected 33", v, edges);
      end
      checks++;
      if (hex_all !== model_hex(v) || overflow !== model_ovf(v)) begin
        failures++;
        $display("FAIL conv_result %h: hex=%h ovf=%b, expected hex=%h ovf=%b",
                 v, hex_all, overflow, model_hex(v), model_ovf(v));
      end
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    @(negedge clk) value_in = 32'd0;
    edges = 0;
    do begin @(posedge clk) #1; edges++; end while ((busy === 1'b1 || edges < 2) && edges < 50);
    checks++;
    if (hex_all !== model_hex(32'd0)) begin
      failures++;
      $display("FAIL b2b_pre: hex=%h, expected %h", hex_all, model_hex(32'd0));
    end
    @(negedge clk) value_in = 32'd5;
    @(posedge clk) #1;  // E0
    for (int k = 1; k <= 67; k++) begin
      @(posedge clk) #1;
      checks++;
      if (HEX0 !== 7'h40 && HEX0 !== 7'h12 && HEX0 !== 7'h78) begin
        failures++;
        $display("FAIL b2b_hex0 E%0d: HEX0=%h, expected 40/12/78", k, HEX0);
      end
      if (k == 33) begin
        checks++;
        if (hex_all !== model_hex(32'd5) || busy !== 1'b0) begin
          failures++;
          $display("FAIL b2b_first E33: hex=%h busy=%b, expected hex=%h busy=0",
                   hex_all, busy, model_hex(32'd5));
        end
      end
      if (k == 34) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL b2b_restart E34: busy=%b, expected 1", busy);
        end
      end
      if (k == 66) begin
        checks++;
        if (hex_all !== model_hex(32'd5)) begin
          failures++;
          $display("FAIL b2b_hold E66: hex=%h, expected %h", hex_all, model_hex(32'd5));
        end
      end
      if (k == 67) begin
        checks++;
        if (hex_all !== model_hex(32'd7) || busy !== 1'b0) begin
          failures++;
          $display("FAIL b2b_second E67: hex=%h busy=%b, expected hex=%h busy=0",
                   hex_all, busy, model_hex(32'd7));
        end
      end
      if (k == 10) @(negedge clk) value_in = 32'd7;
    end
  endtask

  task automatic test_reset_mid();
    int edges;
    @(negedge clk) value_in = 32'd12_345_678;
    @(posedge clk) #1;  // E0
    repeat (20) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    checks++;
    if (hex_all !== reset_hex() || busy !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL midreset_async: hex=%h busy=%b ovf=%b, expected hex=%h busy=0 ovf=0",
               hex_all, busy, overflow, reset_hex());
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk) #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL midreset_restart: busy=%b, expected 1", busy);
    end
    edges = 0;
    while (busy === 1'b1 && edges < 40) begin
      @(posedge clk) #1;
      edges++;
    end
    checks++;
    if (edges != 33 || hex_all !== model_hex(32'd12_345_678) || overflow !== 1'b0) begin
      failures++;
      $display("FAIL midreset_result: edges=%0d hex=%h ovf=%b, expected edges=33 hex=%h ovf=0",
               edges, hex_all, overflow, model_hex(32'd12_345_678));
    end
  endtask

  initial begin
    test_reset();
    test_conversions();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
